sys_cmd_master: RTL and testbench
=================================

SYS_CMD_MASTER -- requirements
Module: sys_cmd_master

Interface
REQ-001 Parameters: WIDTH_REG = 8 (data byte width); ADDR = 4 (register address width); fun = 4 (ALU function code width); TIMEOUT_CYC = 4096 (response timeout, in clock cycles).
REQ-002 One clock, i_Ref_clk; reset i_rst is synchronous and active-high.
REQ-003 i_Ref_clk  in  1  system clock; all state updates on its rising edge.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 i_cmd_vld  in  1 / o_cmd_rdy  out  1  command handshake.
REQ-006 i_cmd_type  in  2  command type: 00 reg write, 01 reg read, 10 ALU with operands, 11 ALU without operands.
REQ-007 i_cmd_addr  in  ADDR  register address; i_cmd_data  in  WIDTH_REG  write data or OP_A; i_cmd_opb  in  WIDTH_REG  OP_B; i_cmd_fun  in  fun  ALU function code.
REQ-008 o_tx_byte  out  8 / o_tx_vld  out  1 / i_tx_rdy  in  1  byte stream toward the UART transmitter.
REQ-009 i_rx_byte  in  8 / i_rx_vld  in  1  received byte; i_rx_vld is a one-cycle pulse.
REQ-010 o_rsp_data  out  16 / o_rsp_vld  out  1 (pulse) / o_rsp_err  out  1 (pulse)  response result; o_busy  out  1  transaction in progress.

Function
REQ-011 FSM states: IDLE, SEND, WAIT_RSP, DONE. o_cmd_rdy = 1 only in IDLE; o_busy = 1 in every state except IDLE.
REQ-012 Command capture: on i_cmd_vld & o_cmd_rdy, all command fields are registered and the FSM moves to SEND.
REQ-013 Frames (byte order):
- Type 00: AA, addr, data.
- Type 01: BB, addr.
- Type 10: CC, A, B, fun.
- Type 11: DD, fun.
- addr and fun are zero-extended to 8 bits.
REQ-014 o_tx_vld asserts the cycle after capture. A byte transfers on o_tx_vld & i_tx_rdy. While o_tx_vld & !i_tx_rdy, o_tx_byte is held stable. The next byte is presented in the cycle after a transfer.
REQ-015 A frame is never interrupted. i_cmd_vld is ignored while not in IDLE.
REQ-016 After the last byte of a type-00 frame transfers, the FSM goes to IDLE. No o_rsp_vld pulse is generated for type 00.
REQ-017 After the last byte of any other frame type transfers, the FSM goes to WAIT_RSP.
- Expected response length: 1 byte for type 01; 2 bytes, LSB first, for types 10/11.
REQ-018 i_rx_vld pulses are ignored outside WAIT_RSP.
REQ-019 Read response: the byte is placed in o_rsp_data[7:0] with [15:8] = 0.
REQ-020 When the final expected byte arrives in cycle M, the FSM enters DONE:
- o_rsp_vld = 1 in cycle M+1 for exactly one cycle;
- the FSM returns to IDLE in cycle M+2.
REQ-021 o_rsp_data holds its value until the next response or timeout.
REQ-022 Simultaneous i_rx_vld and timeout expiry: the received byte takes priority.

Reset
REQ-023 While i_rst = 1 at a clock edge, the following are cleared: FSM = IDLE, byte counter = 0, timeout counter = 0.
REQ-024 Output reset values: o_tx_vld = 0, o_tx_byte = 0, o_rsp_vld = 0, o_rsp_err = 0, o_rsp_data = 0, o_busy = 0, o_cmd_rdy = 1 from the first cycle after reset is released.
REQ-025 Reset asserted mid-frame or mid-wait aborts the transaction. The transaction is never resumed, and no rsp or err pulse is produced for it.

Configuration
REQ-026 Macro SYS_CMD_TIMEOUT_EN defined:
- a counter runs in WAIT_RSP and is reloaded to 0 on each accepted i_rx_vld;
- when it reaches TIMEOUT_CYC-1, o_rsp_vld and o_rsp_err pulse together for one cycle;
- o_rsp_data then holds the bytes received so far, with missing bytes = 0;
- the FSM then returns to IDLE.
REQ-027 Macro undefined: no timeout counter; WAIT_RSP waits indefinitely; o_rsp_err is tied to 0.

Verification
REQ-028 Write: type 00, addr 5, data 0x3C, i_tx_rdy = 1 -> bytes AA, 05, 3C on consecutive cycles; o_cmd_rdy high the cycle after the 3C transfer; no o_rsp_vld.
REQ-029 Read: type 01, addr 2; i_rx_byte 0x81 pulsed in WAIT_RSP -> tx bytes BB, 02; o_rsp_data = 0x0081; o_rsp_vld pulse 1 cycle after the rx pulse.
REQ-030 ALU with operands: type 10, A = 0x10, B = 0x20, fun = 0; i_tx_rdy toggling every other cycle; rx bytes 30, 00 -> tx bytes CC, 10, 20, 00 with each byte stable during stalls; o_rsp_data = 0x0030.
REQ-031 Spurious rx: i_rx_vld pulsed during SEND and during IDLE -> ignored; the later response is still assembled correctly.
REQ-032 Timeout (macro defined, TIMEOUT_CYC = 16): type 11, one rx byte 0x55 then silence -> after 16 idle cycles, o_rsp_vld = o_rsp_err = 1, o_rsp_data = 0x0055, FSM returns to IDLE.
REQ-033 Reset mid-frame: i_rst asserted after the second byte of a type-10 frame -> next cycle o_tx_vld = 0, o_cmd_rdy = 1; a new command then sends a complete, correct frame.

Source files
------------

// File: rtl/sys_cmd_master.sv
// rtl/sys_cmd_master.sv - frames commands into a byte stream and assembles the byte response
// Optional response timeout: define SYS_CMD_TIMEOUT_EN.
module sys_cmd_master #(
  parameter int WIDTH_REG   = 8,
  parameter int ADDR        = 4,
  parameter int fun         = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 i_Ref_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_vld,
  output logic                 o_cmd_rdy,
  input  logic [1:0]           i_cmd_type,
  input  logic [ADDR-1:0]      i_cmd_addr,
  input  logic [WIDTH_REG-1:0] i_cmd_data,
  input  logic [WIDTH_REG-1:0] i_cmd_opb,
  input  logic [fun-1:0]       i_cmd_fun,
  output logic [7:0]           o_tx_byte,
  output logic                 o_tx_vld,
  input  logic                 i_tx_rdy,
  input  logic [7:0]           i_rx_byte,
  input  logic                 i_rx_vld,
  output logic [15:0]          o_rsp_data,
  output logic                 o_rsp_vld,
  output logic                 o_rsp_err,
  output logic                 o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_RSP, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [1:0]           r_type;
  logic [ADDR-1:0]      r_addr;
  logic [WIDTH_REG-1:0] r_data, r_opb;
  logic [fun-1:0]       r_fun;
  logic [2:0]           r_cnt;
  logic [15:0]          r_rx_buf, r_rsp_data;
  logic [2:0]           w_frame_len, w_rsp_len;
  logic [7:0]           w_frame_byte;
  logic                 w_tx_fire, w_tx_last, w_rx_fire, w_rx_last, w_to_expire;

  assign w_tx_fire  = (r_state == S_SEND) && i_tx_rdy;
  assign w_tx_last  = (r_cnt == w_frame_len - 3'd1);
  assign w_rx_fire  = (r_state == S_WAIT_RSP) && i_rx_vld;
  assign w_rx_last  = w_rx_fire && (r_cnt == w_rsp_len - 3'd1);
  assign w_rsp_len  = (r_type == 2'b01) ? 3'd1 : 3'd2;
  assign o_rsp_data = r_rsp_data;

  always_comb begin
    w_frame_len = 3'd2;
    case (r_type)
      2'b00:   w_frame_len = 3'd3;
      2'b10:   w_frame_len = 3'd4;
      default: w_frame_len = 3'd2;
    endcase
  end

  // r_cnt indexes the frame byte while sending and the response byte while waiting
  always_comb begin
    w_frame_byte = 8'h00;
    case (r_type)
      2'b00: case (r_cnt)
        3'd0:    w_frame_byte = 8'hAA;
        3'd1:    w_frame_byte = 8'(r_addr);
        default: w_frame_byte = 8'(r_data);
      endcase
      2'b01: case (r_cnt)
        3'd0:    w_frame_byte = 8'hBB;
        default: w_frame_byte = 8'(r_addr);
      endcase
      2'b10: case (r_cnt)
        3'd0:    w_frame_byte = 8'hCC;
        3'd1:    w_frame_byte = 8'(r_data);
        3'd2:    w_frame_byte = 8'(r_opb);
        default: w_frame_byte = 8'(r_fun);
      endcase
      default: case (r_cnt)
        3'd0:    w_frame_byte = 8'hDD;
        default: w_frame_byte = 8'(r_fun);
      endcase
    endcase
  end

`ifdef SYS_CMD_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;

  // a byte arriving in the expiry cycle wins over the timeout
  assign w_to_expire = (r_state == S_WAIT_RSP) && !i_rx_vld &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_Ref_clk) begin
    if (i_rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state != S_WAIT_RSP || w_rx_fire) r_to_cnt <= '0;
      else                                     r_to_cnt <= r_to_cnt + 1'b1;
      if (w_to_expire)    r_err <= 1'b1;
      else if (w_rx_last) r_err <= 1'b0;
    end
  end
`else
  assign w_to_expire = 1'b0;
`endif

  always_ff @(posedge i_Ref_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (i_cmd_vld) w_next = S_SEND;
      S_SEND:     if (w_tx_fire && w_tx_last) w_next = (r_type == 2'b00) ? S_IDLE : S_WAIT_RSP;
      S_WAIT_RSP: if (w_rx_last || w_to_expire) w_next = S_DONE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Ref_clk) begin
    if (i_rst) begin
      r_cnt      <= 3'd0;
      r_type     <= 2'b00;
      r_addr     <= '0;
      r_data     <= '0;
      r_opb      <= '0;
      r_fun      <= '0;
      r_rx_buf   <= 16'h0000;
      r_rsp_data <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= 3'd0;
          if (i_cmd_vld) begin
            r_type   <= i_cmd_type;
            r_addr   <= i_cmd_addr;
            r_data   <= i_cmd_data;
            r_opb    <= i_cmd_opb;
            r_fun    <= i_cmd_fun;
            r_rx_buf <= 16'h0000;
          end
        end
        S_SEND: if (w_tx_fire) r_cnt <= w_tx_last ? 3'd0 : r_cnt + 3'd1;
        S_WAIT_RSP: begin
          if (w_rx_fire) begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd0) r_rx_buf[7:0]  <= i_rx_byte;
            else               r_rx_buf[15:8] <= i_rx_byte;
            if (w_rx_last)
              r_rsp_data <= (r_cnt == 3'd0) ? {8'h00, i_rx_byte} : {i_rx_byte, r_rx_buf[7:0]};
          end else if (w_to_expire) begin
            r_rsp_data <= r_rx_buf;
          end
        end
        default: r_cnt <= 3'd0;
      endcase
    end
  end

  always_comb begin
    o_cmd_rdy = 1'b0;
    o_busy    = 1'b1;
    o_tx_vld  = 1'b0;
    o_tx_byte = 8'h00;
    o_rsp_vld = 1'b0;
    o_rsp_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_cmd_rdy = 1'b1;
        o_busy    = 1'b0;
      end
      S_SEND: begin
        o_tx_vld  = 1'b1;
        o_tx_byte = w_frame_byte;
      end
      S_DONE: begin
        o_rsp_vld = 1'b1;
`ifdef SYS_CMD_TIMEOUT_EN
        o_rsp_err = r_err;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sys_cmd_master.sv
// tb/tb_sys_cmd_master.sv - directed and randomized checks of sys_cmd_master against a frame/response model
module tb_sys_cmd_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_cmd_vld = 1'b0;
  logic [1:0]  i_cmd_type = 2'b00;
  logic [3:0]  i_cmd_addr = 4'h0;
  logic [7:0]  i_cmd_data = 8'h00;
  logic [7:0]  i_cmd_opb = 8'h00;
  logic [3:0]  i_cmd_fun = 4'h0;
  logic        i_tx_rdy = 1'b0;
  logic [7:0]  i_rx_byte = 8'h00;
  logic        i_rx_vld = 1'b0;
  logic        o_cmd_rdy, o_tx_vld, o_rsp_vld, o_rsp_err, o_busy;
  logic [7:0]  o_tx_byte;
  logic [15:0] o_rsp_data;

  int tests = 0;
  int fails = 0;
  logic [15:0] last_rsp = 16'h0000;

  typedef logic [7:0] bq_t[$];

  always #5 clk = ~clk;

  sys_cmd_master #(.WIDTH_REG(8), .ADDR(4), .fun(4), .TIMEOUT_CYC(TO)) dut (
    .i_Ref_clk(clk), .i_rst(i_rst),
    .i_cmd_vld(i_cmd_vld), .o_cmd_rdy(o_cmd_rdy), .i_cmd_type(i_cmd_type),
    .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_opb(i_cmd_opb), .i_cmd_fun(i_cmd_fun),
    .o_tx_byte(o_tx_byte), .o_tx_vld(o_tx_vld), .i_tx_rdy(i_tx_rdy),
    .i_rx_byte(i_rx_byte), .i_rx_vld(i_rx_vld),
    .o_rsp_data(o_rsp_data), .o_rsp_vld(o_rsp_vld), .o_rsp_err(o_rsp_err), .o_busy(o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference frame contents straight from the command-type table
  function automatic bq_t model_frame(input logic [1:0] t, input logic [3:0] a,
                                      input logic [7:0] d, input logic [7:0] b, input logic [3:0] f);
    bq_t q;
    case (t)
      2'b00:   q = '{8'hAA, {4'h0, a}, d};
      2'b01:   q = '{8'hBB, {4'h0, a}};
      2'b10:   q = '{8'hCC, d, b, {4'h0, f}};
      default: q = '{8'hDD, {4'h0, f}};
    endcase
    return q;
  endfunction

  task automatic send_frame(input string tag, input logic [1:0] t, input logic [3:0] a,
                            input logic [7:0] d, input logic [7:0] b, input logic [3:0] f,
                            input bit stall, input bit noise);
    bq_t exp_q = model_frame(t, a, d, b, f);
    bq_t got_q;
    logic [7:0] held = 8'h00;
    bit hold = 0;
    chk({tag, "/cmd_rdy"}, {31'd0, o_cmd_rdy}, 1);
    i_cmd_vld = 1'b1; i_cmd_type = t; i_cmd_addr = a; i_cmd_data = d; i_cmd_opb = b; i_cmd_fun = f;
    tick();
    i_cmd_vld = 1'b0;
    chk({tag, "/tx_vld_first"}, {31'd0, o_tx_vld}, 1);
    for (int k = 0; k < 64 && got_q.size() < exp_q.size(); k++) begin
      i_tx_rdy = stall ? k[0] : 1'b1;
      if (noise && k == 1) begin
        i_rx_vld = 1'b1; i_rx_byte = 8'($urandom);
        i_cmd_vld = 1'b1; i_cmd_type = 2'($urandom); i_cmd_data = 8'($urandom);
      end
      if (o_tx_vld) begin
        if (hold) chk({tag, "/stall_stable"}, {24'd0, o_tx_byte}, {24'd0, held});
        if (i_tx_rdy) begin got_q.push_back(o_tx_byte); hold = 0; end
        else begin hold = 1; held = o_tx_byte; end
      end
      tick();
      i_rx_vld = 1'b0; i_cmd_vld = 1'b0;
    end
    i_tx_rdy = 1'b0;
    chk({tag, "/frame_len"}, got_q.size(), exp_q.size());
    foreach (exp_q[i]) chk($sformatf("%s/byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] t, input logic [3:0] a,
                         input logic [7:0] d, input logic [7:0] b, input logic [3:0] f,
                         input bit stall, input bit noise, input logic [7:0] r0, input logic [7:0] r1);
    int n;
    logic [7:0] r[2];
    logic [15:0] exp_rsp;
    send_frame(tag, t, a, d, b, f, stall, noise);
    if (t == 2'b00) begin
      chk({tag, "/wr_idle"}, {31'd0, o_cmd_rdy}, 1);
      chk({tag, "/wr_no_rsp"}, {31'd0, o_rsp_vld}, 0);
      chk({tag, "/rsp_held"}, {16'd0, o_rsp_data}, {16'd0, last_rsp});
      return;
    end
    chk({tag, "/wait_busy"}, {30'd0, o_busy, o_cmd_rdy}, 32'h2);
    n = (t == 2'b01) ? 1 : 2;
    r[0] = r0; r[1] = r1;
    exp_rsp = (n == 1) ? {8'h00, r0} : {r1, r0};
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      i_rx_vld = 1'b1; i_rx_byte = r[i];
      tick();
      i_rx_vld = 1'b0;
      if (i < n - 1) chk({tag, "/no_early_rsp"}, {31'd0, o_rsp_vld}, 0);
    end
    chk({tag, "/rsp_vld"}, {30'd0, o_rsp_vld, o_rsp_err}, 32'h2);
    chk({tag, "/rsp_data"}, {16'd0, o_rsp_data}, {16'd0, exp_rsp});
    tick();
    chk({tag, "/rsp_pulse_end"}, {30'd0, o_rsp_vld, o_cmd_rdy}, 32'h1);
    chk({tag, "/rsp_data_hold"}, {16'd0, o_rsp_data}, {16'd0, exp_rsp});
    last_rsp = exp_rsp;
  endtask

  initial begin
    repeat (3) tick();
    i_rst = 1'b0;
    tick();
    chk("reset/cmd_rdy", {31'd0, o_cmd_rdy}, 1);
    chk("reset/outs", {27'd0, o_tx_vld, o_rsp_vld, o_rsp_err, o_busy, 1'b0}, 0);
    chk("reset/tx_byte", {24'd0, o_tx_byte}, 0);
    chk("reset/rsp_data", {16'd0, o_rsp_data}, 0);

    run_cmd("write", 2'b00, 4'h5, 8'h3C, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00);
    tick();
    chk("write/no_late_rsp", {31'd0, o_rsp_vld}, 0);
    run_cmd("read", 2'b01, 4'h2, 8'h00, 8'h00, 4'h0, 0, 0, 8'h81, 8'h00);
    run_cmd("alu_ab", 2'b10, 4'h0, 8'h10, 8'h20, 4'h0, 1, 0, 8'h30, 8'h00);

    // rx pulse in IDLE must not leak into the next response
    i_rx_vld = 1'b1; i_rx_byte = 8'hEE;
    tick();
    i_rx_vld = 1'b0;
    chk("spurious/idle", {30'd0, o_rsp_vld, o_busy}, 0);
    run_cmd("spurious", 2'b10, 4'h0, 8'h12, 8'h34, 4'h9, 0, 1, 8'hA5, 8'h5A);

    // reset after two bytes of a 4-byte frame
    i_cmd_vld = 1'b1; i_cmd_type = 2'b10; i_cmd_data = 8'h77; i_cmd_opb = 8'h88; i_cmd_fun = 4'h3;
    tick();
    i_cmd_vld = 1'b0; i_tx_rdy = 1'b1;
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0; i_tx_rdy = 1'b0;
    chk("midrst/tx_vld", {31'd0, o_tx_vld}, 0);
    chk("midrst/cmd_rdy", {30'd0, o_cmd_rdy, o_busy}, 32'h2);
    chk("midrst/no_rsp", {30'd0, o_rsp_vld, o_rsp_err}, 0);
    last_rsp = 16'h0000;
    run_cmd("after_rst", 2'b10, 4'h0, 8'h9A, 8'hBC, 4'hF, 0, 0, 8'h01, 8'h02);

`ifdef SYS_CMD_TIMEOUT_EN
    begin
      int idle_cyc = 0;
      send_frame("timeout", 2'b11, 4'h0, 8'h00, 8'h00, 4'h6, 0, 0);
      tick();
      i_rx_vld = 1'b1; i_rx_byte = 8'h55;
      tick();
      i_rx_vld = 1'b0;
      for (int k = 0; k < 100 && !o_rsp_vld; k++) begin
        idle_cyc++;
        tick();
      end
      chk("timeout/idle_cycles", idle_cyc, TO);
      chk("timeout/vld_err", {30'd0, o_rsp_vld, o_rsp_err}, 32'h3);
      chk("timeout/data", {16'd0, o_rsp_data}, 32'h0055);
      tick();
      chk("timeout/idle", {29'd0, o_rsp_vld, o_rsp_err, o_cmd_rdy}, 32'h1);
      last_rsp = 16'h0055;
    end
`else
    begin
      bit bad = 0;
      send_frame("no_timeout", 2'b11, 4'h0, 8'h00, 8'h00, 4'h6, 0, 0);
      i_rx_vld = 1'b1; i_rx_byte = 8'h55;
      tick();
      i_rx_vld = 1'b0;
      repeat (3 * TO) begin
        if (o_rsp_vld || o_rsp_err || !o_busy) bad = 1;
        tick();
      end
      chk("no_timeout/still_waiting", {31'd0, bad}, 0);
      i_rx_vld = 1'b1; i_rx_byte = 8'h66;
      tick();
      i_rx_vld = 1'b0;
      chk("no_timeout/vld_err", {30'd0, o_rsp_vld, o_rsp_err}, 32'h2);
      chk("no_timeout/data", {16'd0, o_rsp_data}, 32'h6655);
      tick();
      last_rsp = 16'h6655;
    end
`endif

    for (int n = 0; n < 12; n++) begin
      run_cmd($sformatf("rand%0d", n), 2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
              4'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
